// File: rtl/bram_stream_reader.sv
// Streams a burst of BRAM words from read port B as a valid/ready stream with a 2-entry buffer.
// Optional abort input enabled by defining BRAM_STREAM_READER_ABORT_EN.
module bram_stream_reader #(
   parameter int LEN_DATA = 20,
   parameter int LEN_ADDR = 8
) (
   input  logic                clk,
   input  logic                rst,
`ifdef BRAM_STREAM_READER_ABORT_EN
   input  logic                abort,
`endif
   input  logic                start_valid,
   output logic                start_ready,
   input  logic [LEN_ADDR-1:0] start_addr,
   input  logic [LEN_ADDR:0]   start_len,
   output logic                busy,
   output logic                done,
   output logic                enb,
   output logic [LEN_ADDR-1:0] addrb,
   input  logic [LEN_DATA-1:0] doutb,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LEN_DATA-1:0] out_data,
   output logic                out_last
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [LEN_ADDR:0] ONE = {{LEN_ADDR{1'b0}}, 1'b1};

   state_t              state;
   logic [LEN_ADDR:0]   rem;
   logic                pend;
   logic                pend_last;
   logic                skid_valid;
   logic                skid_last;
   logic [LEN_DATA-1:0] skid_data;
   logic                pop;
   logic                kill;
   logic [1:0]          inflight;

   assign pop = out_valid && out_ready;
`ifdef BRAM_STREAM_READER_ABORT_EN
   assign kill = abort && (state != IDLE);
`else
   assign kill = 1'b0;
`endif

   // Reads in flight plus buffered words; a new read must still fit after this cycle's pop.
   assign inflight    = {1'b0, pend} + {1'b0, out_valid} + {1'b0, skid_valid};
   assign enb         = (state == RUN) && !kill && ((inflight - {1'b0, pop}) < 2'd2);
   assign start_ready = (state == IDLE);
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rem       <= '0;
         addrb     <= '0;
         pend      <= 1'b0;
         pend_last <= 1'b0;
         done      <= 1'b0;
      end else begin
         done      <= 1'b0;
         pend      <= enb;
         pend_last <= enb && (rem == ONE);
         if (enb) begin
            addrb <= addrb + 1'b1;
            rem   <= rem - ONE;
         end
         unique case (state)
            IDLE: begin
               if (start_valid) begin
                  if (start_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state <= RUN;
                     addrb <= start_addr;
                     rem   <= start_len;
                  end
               end
            end
            RUN: begin
               if (kill)
                  state <= IDLE;
               else if (enb && (rem == ONE))
                  state <= DRAIN;
            end
            DRAIN: begin
               if (kill) begin
                  state <= IDLE;
               end else if (pop && out_last) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Head register feeds the stream; the skid entry absorbs the read that was already in flight.
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
      end else if (pop) begin
         if (skid_valid) begin
            out_data <= skid_data;
            out_last <= skid_last;
            if (pend) begin
               skid_data <= doutb;
               skid_last <= pend_last;
            end else begin
               skid_valid <= 1'b0;
            end
         end else if (pend) begin
            out_data <= doutb;
            out_last <= pend_last;
         end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end else if (pend) begin
         if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= doutb;
            out_last  <= pend_last;
         end else begin
            skid_valid <= 1'b1;
            skid_data  <= doutb;
            skid_last  <= pend_last;
         end
      end
   end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural BRAM holding mem[i] = i*3.
// Abort checks are included when BRAM_STREAM_READER_ABORT_EN is defined.
module tb_bram_stream_reader;
   logic        clk = 1'b0;
   logic        rst;
   logic        abort;
   logic        start_valid;
   logic        start_ready;
   logic [7:0]  start_addr;
   logic [8:0]  start_len;
   logic        busy;
   logic        done;
   logic        enb;
   logic [7:0]  addrb;
   logic [19:0] doutb;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] out_data;
   logic        out_last;

   logic [19:0] mem [256];
   int n_chk = 0;
   int n_fail = 0;

   bram_stream_reader #(.LEN_DATA(20), .LEN_ADDR(8)) dut (
      .clk(clk),
      .rst(rst),
`ifdef BRAM_STREAM_READER_ABORT_EN
      .abort(abort),
`endif
      .start_valid(start_valid),
      .start_ready(start_ready),
      .start_addr(start_addr),
      .start_len(start_len),
      .busy(busy),
      .done(done),
      .enb(enb),
      .addrb(addrb),
      .doutb(doutb),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (enb) doutb <= mem[addrb];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic nc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_burst(input logic [7:0] a, input int len, input int mode);
      int          issued;
      int          popped;
      int          cyc;
      int          pop_i;
      bit          seen;
      bit          stall;
      logic [19:0] hd;
      logic        hl;
      logic [7:0]  ea;
      issued = 0; popped = 0; cyc = 0; seen = 0; stall = 0; hd = '0; hl = 1'b0;
      nc();
      start_addr = a; start_len = 9'(len); start_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("burst_start_ready", start_ready, 1);
      nc();
      start_valid = 1'b0;
      while (!seen && cyc < len * 4 + 20) begin
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         #1;
         pop_i = (out_valid && out_ready) ? 1 : 0;
         if (stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, hd);
            chk("hold_last", out_last, hl);
         end
         if (enb) begin
            ea = a + issued[7:0];
            chk("addrb", addrb, ea);
            chk("outstanding_le2", (issued - popped - pop_i) < 2, 1);
            chk("extra_read", issued < len, 1);
            issued++;
         end
         if (pop_i == 1) begin
            ea = a + popped[7:0];
            chk("data", out_data, int'(ea) * 3);
            chk("last", out_last, popped == len - 1);
            popped++;
         end
         stall = out_valid && !out_ready;
         hd = out_data;
         hl = out_last;
         if (done) begin
            seen = 1;
            chk("done_start_ready", start_ready, 1);
            chk("done_busy", busy, 0);
         end
         cyc++;
         nc();
      end
      #1;
      chk("done_seen", seen, 1);
      chk("words_popped", popped, len);
      chk("reads_issued", issued, len);
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 20'(i * 3);
      rst = 1'b1; abort = 1'b0; start_valid = 1'b0; start_addr = '0; start_len = '0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) nc();
      #1;
      chk("rst_start_ready", start_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_enb", enb, 0);
      chk("rst_addrb", addrb, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      nc();
      rst = 1'b0;

      // Basic burst with exact cycle timing: addr 0x10, len 4
      nc();
      start_addr = 8'h10; start_len = 9'd4; start_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("b_T_ready", start_ready, 1);
      chk("b_T_enb", enb, 0);
      nc(); start_valid = 1'b0; #1;
      chk("b_T1_enb", enb, 1);
      chk("b_T1_addrb", addrb, 8'h10);
      chk("b_T1_busy", busy, 1);
      chk("b_T1_start_ready", start_ready, 0);
      chk("b_T1_valid", out_valid, 0);
      nc(); #1;
      chk("b_T2_enb", enb, 1);
      chk("b_T2_addrb", addrb, 8'h11);
      chk("b_T2_valid", out_valid, 0);
      nc(); #1;
      chk("b_T3_valid", out_valid, 1);
      chk("b_T3_data", out_data, 20'h30);
      chk("b_T3_last", out_last, 0);
      start_valid = 1'b1; start_addr = 8'h00; start_len = 9'd3;
      nc(); #1;
      chk("b_T4_data", out_data, 20'h33);
      chk("b_T4_valid", out_valid, 1);
      start_valid = 1'b0;
      nc(); #1;
      chk("b_T5_data", out_data, 20'h36);
      chk("b_T5_last", out_last, 0);
      nc(); #1;
      chk("b_T6_data", out_data, 20'h39);
      chk("b_T6_last", out_last, 1);
      chk("b_T6_done", done, 0);
      nc(); #1;
      chk("b_T7_valid", out_valid, 0);
      chk("b_T7_done", done, 1);
      chk("b_T7_start_ready", start_ready, 1);
      chk("b_T7_busy", busy, 0);
      nc(); #1;
      chk("b_T8_done", done, 0);
      chk("b_T8_enb", enb, 0);
      chk("b_T8_busy_not_queued", busy, 0);

      // Address wrap FE,FF,00,01
      run_burst(8'hFE, 4, 0);

      // Backpressure with out_ready pattern 1,0,0 repeating
      run_burst(8'h80, 8, 1);

      // Zero length: done pulse only
      nc();
      start_addr = 8'h33; start_len = 9'd0; start_valid = 1'b1;
      #1;
      chk("z_T_enb", enb, 0);
      nc(); start_valid = 1'b0; #1;
      chk("z_T1_done", done, 1);
      chk("z_T1_enb", enb, 0);
      chk("z_T1_busy", busy, 0);
      chk("z_T1_valid", out_valid, 0);
      nc(); #1;
      chk("z_T2_done", done, 0);
      chk("z_T2_enb", enb, 0);

      // Full-depth burst
      run_burst(8'h07, 256, 0);

      // Reset at word 3 of a 10-word burst
      nc();
      start_addr = 8'h20; start_len = 9'd10; start_valid = 1'b1; out_ready = 1'b1;
      nc(); start_valid = 1'b0;
      repeat (5) nc();
      #1;
      chk("r_word3_valid", out_valid, 1);
      chk("r_word3_data", out_data, 20'h69);
      rst = 1'b1;
      nc(); rst = 1'b0; #1;
      chk("r_start_ready", start_ready, 1);
      chk("r_busy", busy, 0);
      chk("r_done", done, 0);
      chk("r_enb", enb, 0);
      chk("r_addrb", addrb, 0);
      chk("r_out_valid", out_valid, 0);
      chk("r_out_data", out_data, 0);
      chk("r_out_last", out_last, 0);
      nc(); #1;
      chk("r_after_valid", out_valid, 0);
      chk("r_after_done", done, 0);
      run_burst(8'h40, 2, 0);

`ifdef BRAM_STREAM_READER_ABORT_EN
      // Abort while the buffer is full and stalled
      nc();
      start_addr = 8'h00; start_len = 9'd8; start_valid = 1'b1; out_ready = 1'b0;
      nc(); start_valid = 1'b0;
      repeat (4) nc();
      #1;
      chk("a_stall_valid", out_valid, 1);
      chk("a_stall_data", out_data, 20'h0);
      chk("a_full_enb", enb, 0);
      abort = 1'b1;
      #1;
      chk("a_abort_enb", enb, 0);
      nc(); abort = 1'b0; #1;
      chk("a_valid", out_valid, 0);
      chk("a_start_ready", start_ready, 1);
      chk("a_busy", busy, 0);
      chk("a_done", done, 0);
      chk("a_enb", enb, 0);
      nc(); #1;
      chk("a_done_late", done, 0);
      chk("a_valid_late", out_valid, 0);
      run_burst(8'h05, 2, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
